// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - CSR map, CTRL/STAT bit positions and FSM states for the packet arbiter
package axis_arb_pkg;

   localparam logic [1:0] ADDR_CTRL = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd1;
   localparam logic [1:0] ADDR_CNT0 = 2'd2;
   localparam logic [1:0] ADDR_CNT1 = 2'd3;

   localparam int CTRL_EN0  = 0;
   localparam int CTRL_EN1  = 1;
   localparam int CTRL_PRIO = 2;
   localparam int CTRL_CLR  = 31;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_GRANT = 1;
   localparam int STAT_LAST  = 2;
   localparam int STAT_PEND  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester arbiter, fixed (s0 wins) or round-robin against last_grant
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       prio,
   output logic       grant
);

   // Output is only meaningful when at least one request is present.
   always_comb begin
      grant = 1'b0;
      if (prio) begin
         grant = ~req[0];
      end else if (req == 2'b11) begin
         grant = ~last_grant;
      end else begin
         grant = req[1] & ~req[0];
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular 2:1 stream arbiter with CSR enables, priority mode and packet counters
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        avs_address,
   input  logic              avs_chipselect,
   input  logic              avs_write_n,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic              s0_tvalid,
   input  logic              s0_tlast,
   output logic              s0_tready,
   input  logic [DATA_W-1:0] s1_tdata,
   input  logic              s1_tvalid,
   input  logic              s1_tlast,
   output logic              s1_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready
);

   arb_state_t       state, state_nx;
   logic             grant, last_grant, arb_grant;
   logic [2:0]       ctrl;
   logic [CNT_W-1:0] cnt0, cnt1;
   logic [1:0]       pending;
   logic             csr_wr, ctrl_wr, clr_cnt, eop;
   logic             unused_wdata;

   assign csr_wr       = avs_chipselect & ~avs_write_n;
   assign ctrl_wr      = csr_wr & (avs_address == ADDR_CTRL);
   assign clr_cnt      = ctrl_wr & avs_writedata[CTRL_CLR];
   assign unused_wdata = ^avs_writedata[30:3];

   assign pending = {s1_tvalid & ctrl[CTRL_EN1], s0_tvalid & ctrl[CTRL_EN0]};

   rr_arb2 u_arb (
      .req        (pending),
      .last_grant (last_grant),
      .prio       (ctrl[CTRL_PRIO]),
      .grant      (arb_grant)
   );

   // Pure combinational routing while a packet owns the sink; nothing moves in IDLE.
   always_comb begin
      state_nx  = state;
      m_tvalid  = 1'b0;
      m_tdata   = '0;
      m_tlast   = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      eop       = 1'b0;
      case (state)
         IDLE: begin
            if (|pending) state_nx = BUSY;
         end
         BUSY: begin
            if (grant) begin
               m_tvalid  = s1_tvalid;
               m_tdata   = s1_tdata;
               m_tlast   = s1_tlast;
               s1_tready = m_tready;
            end else begin
               m_tvalid  = s0_tvalid;
               m_tdata   = s0_tdata;
               m_tlast   = s0_tlast;
               s0_tready = m_tready;
            end
            eop = m_tvalid & m_tready & m_tlast;
            if (eop) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         ctrl       <= '0;
         cnt0       <= '0;
         cnt1       <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && |pending) grant <= arb_grant;
         if (eop) last_grant <= grant;
         if (ctrl_wr) ctrl <= avs_writedata[2:0];
         // A clear in the same cycle as a packet completion leaves the counter at zero.
         if (clr_cnt) begin
            cnt0 <= '0;
            cnt1 <= '0;
         end else if (eop) begin
            if (grant) cnt1 <= cnt1 + CNT_W'(1);
            else       cnt0 <= cnt0 + CNT_W'(1);
         end
      end
   end

   always_comb begin
      avs_readdata = '0;
      case (avs_address)
         ADDR_CTRL: avs_readdata[2:0] = ctrl;
         ADDR_STAT: begin
            avs_readdata[STAT_BUSY]      = (state == BUSY);
            avs_readdata[STAT_GRANT]     = grant;
            avs_readdata[STAT_LAST]      = last_grant;
            avs_readdata[STAT_PEND +: 2] = pending;
         end
         ADDR_CNT0: avs_readdata[CNT_W-1:0] = cnt0;
         default:   avs_readdata[CNT_W-1:0] = cnt1;
      endcase
   end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - vector table, directed corner sequences and randomized traffic against a packet-level model
module tb_axis_pkt_arbiter;

   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    avs_address;
   logic          avs_chipselect;
   logic          avs_write_n;
   logic [31:0]   avs_writedata;
   logic [31:0]   avs_readdata;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic          s0_tvalid, s0_tlast, s0_tready;
   logic          s1_tvalid, s1_tlast, s1_tready;
   logic          m_tvalid, m_tlast, m_tready;

   axis_pkt_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .avs_address    (avs_address),
      .avs_chipselect (avs_chipselect),
      .avs_write_n    (avs_write_n),
      .avs_writedata  (avs_writedata),
      .avs_readdata   (avs_readdata),
      .s0_tdata       (s0_tdata),
      .s0_tvalid      (s0_tvalid),
      .s0_tlast       (s0_tlast),
      .s0_tready      (s0_tready),
      .s1_tdata       (s1_tdata),
      .s1_tvalid      (s1_tvalid),
      .s1_tlast       (s1_tlast),
      .s1_tready      (s1_tready),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid),
      .m_tlast        (m_tlast),
      .m_tready       (m_tready)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       v0;
      logic       l0;
      logic [7:0] d0;
      logic       v1;
      logic       l1;
      logic [7:0] d1;
      logic       rdy;
      logic       emv;
      logic       eml;
      logic [7:0] emd;
      logic       er0;
      logic       er1;
   } vec_t;

   vec_t        tbl [13];
   logic [31:0] rd;
   logic [7:0]  pkt [3];
   int          idx_bp, c0_before;
   logic        tog, hs_bp;

   // Randomized-phase source and reference state
   int          left [2], len [2], idx [2], mcnt [2];
   logic        vld [2], lst [2], hs [2];
   logic [7:0]  dat [2];
   int          owner, mlast, cyc;
   logic        prio_r;
   logic [11:0] e_vec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      avs_address    = a;
      avs_writedata  = d;
      avs_chipselect = 1'b1;
      avs_write_n    = 1'b0;
      @(posedge clk);
      #1;
      avs_chipselect = 1'b0;
      avs_write_n    = 1'b1;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      #1;
      d = avs_readdata;
   endtask

   function automatic logic [11:0] act_vec();
      return {m_tvalid, m_tvalid & m_tlast, (m_tvalid ? m_tdata : 8'h00), s0_tready, s1_tready};
   endfunction

   // Arbitration rule: fixed mode favours s0; round-robin favours the source not served last.
   function automatic int pick(input logic [1:0] p, input logic pr, input int lg);
      if (pr && p[0]) return 0;
      if (p == 2'b11) return 1 - lg;
      return p[0] ? 0 : 1;
   endfunction

   initial begin
      reset = 1'b1;
      avs_address = 2'd0; avs_chipselect = 1'b0; avs_write_n = 1'b1; avs_writedata = '0;
      s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
      s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
      m_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_outputs", 32'({m_tvalid, s0_tready, s1_tready}), 32'd0);
      csr_rd(2'd0, rd); chk("rst_ctrl", rd, 32'h0);
      csr_rd(2'd1, rd); chk("rst_stat", rd, 32'h4);
      csr_rd(2'd2, rd); chk("rst_cnt0", rd, 32'h0);
      csr_rd(2'd3, rd); chk("rst_cnt1", rd, 32'h0);

      // Single source then round-robin contention, one row per cycle
      tbl[0]  = '{1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,8'h11, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,8'h11,1'b1,1'b0};
      tbl[2]  = '{1'b1,1'b0,8'h12, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,8'h12,1'b1,1'b0};
      tbl[3]  = '{1'b1,1'b0,8'h13, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,8'h13,1'b1,1'b0};
      tbl[4]  = '{1'b1,1'b1,8'h14, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b1,8'h14,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b1,8'h21, 1'b1,1'b1,8'h31, 1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0};
      tbl[6]  = '{1'b1,1'b1,8'h21, 1'b1,1'b1,8'h31, 1'b1, 1'b1,1'b1,8'h31,1'b0,1'b1};
      tbl[7]  = '{1'b1,1'b1,8'h21, 1'b1,1'b1,8'h32, 1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0};
      tbl[8]  = '{1'b1,1'b1,8'h21, 1'b1,1'b1,8'h32, 1'b1, 1'b1,1'b1,8'h21,1'b1,1'b0};
      tbl[9]  = '{1'b1,1'b1,8'h22, 1'b1,1'b1,8'h32, 1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b1,8'h22, 1'b1,1'b1,8'h32, 1'b0, 1'b1,1'b1,8'h32,1'b0,1'b0};
      tbl[11] = '{1'b1,1'b1,8'h22, 1'b1,1'b1,8'h32, 1'b1, 1'b1,1'b1,8'h32,1'b0,1'b1};
      tbl[12] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0};

      csr_wr(2'd0, 32'h3);
      for (int i = 0; i < 13; i++) begin
         s0_tvalid = tbl[i].v0; s0_tlast = tbl[i].l0; s0_tdata = tbl[i].d0;
         s1_tvalid = tbl[i].v1; s1_tlast = tbl[i].l1; s1_tdata = tbl[i].d1;
         m_tready  = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'(act_vec()),
             32'({tbl[i].emv, tbl[i].eml, tbl[i].emd, tbl[i].er0, tbl[i].er1}));
         @(posedge clk);
         #1;
      end
      csr_rd(2'd2, rd); chk("tbl_cnt0", rd, 32'd2);
      csr_rd(2'd3, rd); chk("tbl_cnt1", rd, 32'd2);
      csr_rd(2'd1, rd); chk("tbl_stat", rd, 32'h6);

      // Fixed priority: both request 1-beat packets continuously, only s0 is served
      csr_wr(2'd0, 32'h7);
      csr_rd(2'd2, rd); c0_before = int'(rd);
      s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 8'hA0;
      s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 8'hB0;
      m_tready  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("fixed_s1_tready", 32'(s1_tready), 32'd0);
         @(posedge clk);
         #1;
      end
      csr_rd(2'd1, rd); chk("fixed_pending", 32'(rd[17:16]), 32'd3);
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      csr_rd(2'd2, rd); chk("fixed_cnt0", rd, 32'((c0_before + 5) % 256));
      csr_rd(2'd3, rd); chk("fixed_cnt1", rd, 32'd2);

      // Backpressure with en0 cleared after the first beat of a 3-beat packet
      csr_wr(2'd0, 32'h3);
      pkt[0] = 8'h61; pkt[1] = 8'h62; pkt[2] = 8'h63;
      idx_bp = 0; tog = 1'b0;
      s0_tvalid = 1'b1; s0_tdata = pkt[0]; s0_tlast = 1'b0;
      for (int c = 0; c < 30 && idx_bp < 3; c++) begin
         m_tready = tog;
         tog = ~tog;
         @(negedge clk);
         if (m_tvalid) chk("bp_data", 32'(m_tdata), 32'(pkt[idx_bp]));
         hs_bp = m_tvalid & m_tready & s0_tready;
         @(posedge clk);
         #1;
         avs_chipselect = 1'b0; avs_write_n = 1'b1;
         if (hs_bp) begin
            idx_bp++;
            if (idx_bp == 1) begin
               avs_address = 2'd0; avs_writedata = 32'h2;
               avs_chipselect = 1'b1; avs_write_n = 1'b0;
            end
            if (idx_bp < 3) begin
               s0_tdata = pkt[idx_bp];
               s0_tlast = (idx_bp == 2);
            end
         end
      end
      avs_chipselect = 1'b0; avs_write_n = 1'b1;
      chk("bp_beats", 32'(idx_bp), 32'd3);
      s0_tdata = 8'h70; s0_tlast = 1'b1; m_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("bp_no_regrant", 32'({m_tvalid, s0_tready}), 32'd0);
         @(posedge clk);
         #1;
      end
      csr_rd(2'd1, rd); chk("bp_pending", 32'(rd[17:16]), 32'd0);
      csr_rd(2'd0, rd); chk("bp_ctrl", rd, 32'h2);
      csr_rd(2'd2, rd); chk("bp_cnt0", rd, 32'((c0_before + 6) % 256));
      s0_tvalid = 1'b0;

      // Counter wrap, then a clear coinciding with a tlast handshake
      csr_wr(2'd0, 32'h8000_0001);
      s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 8'h5A; m_tready = 1'b1;
      repeat (2 * 255) @(posedge clk);
      #1;
      csr_rd(2'd2, rd); chk("wrap_cnt0_255", rd, 32'd255);
      repeat (2) @(posedge clk);
      #1;
      csr_rd(2'd2, rd); chk("wrap_cnt0_0", rd, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      csr_rd(2'd2, rd); chk("wrap_cnt0_3", rd, 32'd3);
      @(posedge clk);
      #1;
      csr_wr(2'd0, 32'h8000_0001);
      s0_tvalid = 1'b0;
      csr_rd(2'd2, rd); chk("clr_vs_eop_cnt0", rd, 32'd0);

      // Reset mid-packet; last_grant is s0 here, so s1 would win without the reset
      csr_wr(2'd0, 32'h3);
      s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 8'h81;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s0_tdata = 8'h82;
      @(posedge clk); #1;
      s0_tdata = 8'h83;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstmid_mvalid", 32'(m_tvalid), 32'd0);
      csr_rd(2'd1, rd); chk("rstmid_stat", rd, 32'h4);
      csr_rd(2'd2, rd); chk("rstmid_cnt0", rd, 32'd0);
      s1_tvalid = 1'b1; s1_tdata = 8'h91; s1_tlast = 1'b1;
      csr_wr(2'd0, 32'h3);
      @(posedge clk); #1;
      chk("rstmid_regrant_s0", 32'({s0_tready, s1_tready, m_tdata}), 32'({1'b1, 1'b0, 8'h83}));
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Randomized traffic against the packet-level reference
      owner = -1; mlast = 1; mcnt[0] = 0; mcnt[1] = 0;
      for (int ph = 0; ph < 4; ph++) begin
         prio_r = ph[0];
         csr_wr(2'd0, {29'd0, prio_r, 2'b11});
         for (int s = 0; s < 2; s++) begin
            left[s] = 6; len[s] = 0; idx[s] = 0;
            vld[s] = 1'b0; lst[s] = 1'b0; dat[s] = 8'h00; hs[s] = 1'b0;
         end
         cyc = 0;
         while (cyc < 3000 && !(left[0] == 0 && left[1] == 0 && owner < 0)) begin
            for (int s = 0; s < 2; s++) begin
               if (hs[s]) begin
                  vld[s] = 1'b0;
                  idx[s]++;
                  if (idx[s] == len[s]) begin
                     len[s] = 0; idx[s] = 0; left[s]--;
                  end
               end
               if (!vld[s] && left[s] > 0 && $urandom_range(0, 3) != 0) begin
                  if (len[s] == 0) len[s] = int'($urandom_range(1, 4));
                  vld[s] = 1'b1;
                  dat[s] = 8'($urandom);
                  lst[s] = (idx[s] == len[s] - 1);
               end
            end
            s0_tvalid = vld[0]; s0_tdata = dat[0]; s0_tlast = lst[0];
            s1_tvalid = vld[1]; s1_tdata = dat[1]; s1_tlast = lst[1];
            m_tready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_vec = '0;
            if (owner >= 0) begin
               if (vld[owner]) e_vec[11:2] = {1'b1, lst[owner], dat[owner]};
               if (owner == 0) e_vec[1] = m_tready;
               else            e_vec[0] = m_tready;
            end
            chk("rand_cycle", 32'(act_vec()), 32'(e_vec));
            hs[0] = 1'b0; hs[1] = 1'b0;
            if (owner < 0) begin
               if (vld[0] || vld[1]) owner = pick({vld[1], vld[0]}, prio_r, mlast);
            end else if (vld[owner] && m_tready) begin
               hs[owner] = 1'b1;
               if (lst[owner]) begin
                  mcnt[owner]++;
                  mlast = owner;
                  owner = -1;
               end
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         chk("rand_drain", 32'(cyc < 3000), 32'd1);
         s0_tvalid = 1'b0; s1_tvalid = 1'b0;
         csr_rd(2'd2, rd); chk("rand_cnt0", rd, 32'(mcnt[0] % 256));
         csr_rd(2'd3, rd); chk("rand_cnt1", rd, 32'(mcnt[1] % 256));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
